lif_potential_array: RTL and testbench

//  Time-multiplexed LIF membrane-potential unit for N_NEURONS neurons, replacing per-neuron adders.

---
 rtl/lif_potential_array.sv | 177 +++++++++++++++++
 tb/tb_lif_potential_array.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_potential_array.sv
// Time-multiplexed leaky integrate-and-fire potential store for N_NEURONS neurons.
// One shared adder/comparator updates a potential RAM from weighted input events; a
// timestep pulse starts a sweep that applies shift-based leak to every neuron, one per
// cycle, and counts down the refractory timers.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   in_valid_i/in_ready_o input event handshake; ready drops in SWEEP and on ts_step_i
//   in_neuron_id_i        target neuron of the event
//   in_weight_i           signed weight added to the target potential
//   ts_step_i             timestep pulse, starts a leak sweep from IDLE
//   cfg_threshold_i       signed firing threshold
//   cfg_reset_mode_i      0: subtract threshold on spike, 1: reset potential to zero
//   cfg_leak_shift_i      leak v <- v - (v >>> shift); 0 disables leak
//   upd_valid_o           one-cycle pulse, event result valid
//   upd_id_o              neuron of the result (held)
//   upd_potential_o       post-update potential (held)
//   spike_o               neuron fired, qualified by upd_valid_o
//   busy_o                sweep in progress
//   done_o                one-cycle pulse as the sweep returns to IDLE
module lif_potential_array #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned N_NEURONS    = 4,
    parameter int unsigned REFRAC_STEPS = 2,
    localparam int unsigned IDW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int unsigned RW  = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [IDW-1:0]          in_neuron_id_i,
    input  logic signed [WIDTH-1:0] in_weight_i,
    input  logic                    ts_step_i,
    input  logic signed [WIDTH-1:0] cfg_threshold_i,
    input  logic                    cfg_reset_mode_i,
    input  logic [3:0]              cfg_leak_shift_i,
    output logic                    upd_valid_o,
    output logic [IDW-1:0]          upd_id_o,
    output logic signed [WIDTH-1:0] upd_potential_o,
    output logic                    spike_o,
    output logic                    busy_o,
    output logic                    done_o
);
    // Two guard bits cover both v + w and (saturated sum) - threshold without wrap.
    localparam int unsigned EW = WIDTH + 2;
    localparam logic signed [EW-1:0] SatMax = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SatMin = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic [IDW-1:0] LastIdx    = IDW'(N_NEURONS - 1);
    localparam logic [RW-1:0]  RefracLoad = RW'(REFRAC_STEPS);

    typedef enum logic {StIdle, StSweep} state_e;

    state_e                  state_q, state_d;
    logic [IDW-1:0]          idx_q, idx_d;
    logic signed [WIDTH-1:0] v_q [N_NEURONS];
    logic signed [WIDTH-1:0] v_d [N_NEURONS];
    logic [RW-1:0]           refrac_q [N_NEURONS];
    logic [RW-1:0]           refrac_d [N_NEURONS];
    logic                    upd_valid_q, upd_valid_d;
    logic                    spike_q, spike_d;
    logic                    done_q, done_d;
    logic [IDW-1:0]          upd_id_q, upd_id_d;
    logic signed [WIDTH-1:0] upd_potential_q, upd_potential_d;

    logic                    accept, id_ok, fire;
    logic signed [WIDTH-1:0] cur_v, sum_sat, fired_v, sweep_v, leak_v;
    logic signed [EW-1:0]    sum_ext, rem_ext;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] x);
        if (x > SatMax) begin
            return SatMax[WIDTH-1:0];
        end else if (x < SatMin) begin
            return SatMin[WIDTH-1:0];
        end
        return x[WIDTH-1:0];
    endfunction

    assign in_ready_o = (state_q == StIdle) && !ts_step_i;
    assign busy_o     = (state_q == StSweep);
    assign accept     = in_valid_i && in_ready_o;
    assign id_ok      = 32'(in_neuron_id_i) < N_NEURONS;

    // Event datapath. Writes land in v_q at the accepting edge, so a back-to-back event
    // to the same neuron already reads the updated value.
    assign cur_v   = v_q[in_neuron_id_i];
    assign sum_ext = EW'(cur_v) + EW'(in_weight_i);
    assign sum_sat = sat(sum_ext);
    assign fire    = (sum_sat >= cfg_threshold_i);
    assign rem_ext = EW'(sum_sat) - EW'(cfg_threshold_i);
    assign fired_v = cfg_reset_mode_i ? '0 : sat(rem_ext);

    // Leak result lies between 0 and v, so it cannot overflow.
    assign sweep_v = v_q[idx_q];
    assign leak_v  = (cfg_leak_shift_i == 4'd0) ? sweep_v
                                                : sweep_v - (sweep_v >>> cfg_leak_shift_i);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        v_d             = v_q;
        refrac_d        = refrac_q;
        upd_valid_d     = 1'b0;
        spike_d         = 1'b0;
        done_d          = 1'b0;
        upd_id_d        = upd_id_q;
        upd_potential_d = upd_potential_q;

        unique case (state_q)
            StIdle: begin
                if (ts_step_i) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end else if (accept && id_ok) begin
                    upd_valid_d = 1'b1;
                    upd_id_d    = in_neuron_id_i;
                    if (refrac_q[in_neuron_id_i] != '0) begin
                        upd_potential_d = cur_v;
                    end else if (fire) begin
                        spike_d                   = 1'b1;
                        v_d[in_neuron_id_i]      = fired_v;
                        refrac_d[in_neuron_id_i] = RefracLoad;
                        upd_potential_d           = fired_v;
                    end else begin
                        v_d[in_neuron_id_i] = sum_sat;
                        upd_potential_d      = sum_sat;
                    end
                end
            end
            StSweep: begin
                v_d[idx_q] = leak_v;
                if (refrac_q[idx_q] != '0) begin
                    refrac_d[idx_q] = refrac_q[idx_q] - RW'(1);
                end
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            v_q             <= '{default: '0};
            refrac_q        <= '{default: '0};
            upd_valid_q     <= 1'b0;
            spike_q         <= 1'b0;
            done_q          <= 1'b0;
            upd_id_q        <= '0;
            upd_potential_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            v_q             <= v_d;
            refrac_q        <= refrac_d;
            upd_valid_q     <= upd_valid_d;
            spike_q         <= spike_d;
            done_q          <= done_d;
            upd_id_q        <= upd_id_d;
            upd_potential_q <= upd_potential_d;
        end
    end

    assign upd_valid_o     = upd_valid_q;
    assign spike_o         = spike_q;
    assign done_o          = done_q;
    assign upd_id_o        = upd_id_q;
    assign upd_potential_o = upd_potential_q;

endmodule

// File: tb/tb_lif_potential_array.sv
// Self-checking bench for lif_potential_array (WIDTH=16, N_NEURONS=4, REFRAC_STEPS=2).
// Directed scenarios check literal expected values; a randomized phase checks every event
// result against a plain-arithmetic neuron model.
module tb_lif_potential_array;
    localparam int N      = 4;
    localparam int REFRAC = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_neuron_id = '0;
    logic signed [15:0] in_weight = '0;
    logic              ts_step = 1'b0;
    logic signed [15:0] cfg_threshold = 16'sd100;
    logic              cfg_reset_mode = 1'b0;
    logic [3:0]        cfg_leak_shift = 4'd0;
    logic              upd_valid;
    logic [1:0]        upd_id;
    logic signed [15:0] upd_potential;
    logic              spike;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;
    int mv [N];
    int mr [N];

    lif_potential_array #(
        .WIDTH       (16),
        .N_NEURONS   (N),
        .REFRAC_STEPS(REFRAC)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_neuron_id_i  (in_neuron_id),
        .in_weight_i     (in_weight),
        .ts_step_i       (ts_step),
        .cfg_threshold_i (cfg_threshold),
        .cfg_reset_mode_i(cfg_reset_mode),
        .cfg_leak_shift_i(cfg_leak_shift),
        .upd_valid_o     (upd_valid),
        .upd_id_o        (upd_id),
        .upd_potential_o (upd_potential),
        .spike_o         (spike),
        .busy_o          (busy),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_event(input int id, input int w, output int pot, output bit sp);
        int s;
        sp = 1'b0;
        if (mr[id] != 0) begin
            pot = mv[id];
        end else begin
            s = sat16(mv[id] + w);
            if (s >= int'(cfg_threshold)) begin
                sp     = 1'b1;
                mv[id] = cfg_reset_mode ? 0 : sat16(s - int'(cfg_threshold));
                mr[id] = REFRAC;
            end else begin
                mv[id] = s;
            end
            pot = mv[id];
        end
    endtask

    task automatic model_sweep();
        for (int n = 0; n < N; n++) begin
            if (cfg_leak_shift != 0) mv[n] = mv[n] - (mv[n] >>> cfg_leak_shift);
            if (mr[n] > 0) mr[n] = mr[n] - 1;
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset(input logic signed [15:0] thr, input logic mode, input logic [3:0] sh);
        cfg_threshold  = thr;
        cfg_reset_mode = mode;
        cfg_leak_shift = sh;
        in_valid = 1'b0;
        ts_step  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < N; n++) begin
            mv[n] = 0;
            mr[n] = 0;
        end
    endtask

    // Presents one event for one cycle; returns #1 after the accepting edge.
    task automatic drive_event(input int id, input int w);
        in_valid     = 1'b1;
        in_neuron_id = 2'(id);
        in_weight    = 16'(w);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_sweep();
        ts_step = 1'b1;
        @(posedge clk);
        #1 ts_step = 1'b0;
        repeat (N) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(16'sd100, 1'b0, 4'd0);
        drive_event(1, 7);
        do_reset(16'sd100, 1'b0, 4'd0);
        n_checks++;
        if ({upd_valid, spike, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got v%b s%b b%b d%b want all 0", upd_valid, spike, busy, done);
        end
        n_checks++;
        if (upd_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_upd_id: got %0d want 0", upd_id);
        end
        n_checks++;
        if (upd_potential !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_upd_potential: got %0d want 0", upd_potential);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        drive_event(1, 5);
        n_checks++;
        if (upd_potential !== 16'sd5) begin
            n_fail++;
            $display("FAIL reset_cleared_potential: got %0d want 5", upd_potential);
        end
    endtask

    task automatic test_accumulate();
        int exp_p;
        for (int m = 0; m < 2; m++) begin
            do_reset(16'sd100, m[0], 4'd0);
            for (int k = 0; k < 2; k++) begin
                drive_event(2, 60);
                exp_p = (k == 0) ? 60 : ((m == 0) ? 20 : 0);
                n_checks++;
                if ({upd_valid, upd_id} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL acc_valid_id m%0d k%0d: got v%b id%0d want v1 id2", m, k, upd_valid, upd_id);
                end
                n_checks++;
                if (upd_potential !== 16'(exp_p)) begin
                    n_fail++;
                    $display("FAIL acc_potential m%0d k%0d: got %0d want %0d", m, k, upd_potential, exp_p);
                end
                n_checks++;
                if (spike !== (k == 1)) begin
                    n_fail++;
                    $display("FAIL acc_spike m%0d k%0d: got %b want %b", m, k, spike, k == 1);
                end
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({upd_valid, spike, upd_potential} !== {2'b00, 16'(exp_p)}) begin
                n_fail++;
                $display("FAIL acc_pulse_hold m%0d: got v%b s%b p%0d want v0 s0 p%0d", m, upd_valid, spike, upd_potential, exp_p);
            end
        end
    endtask

    task automatic test_refractory();
        int ids [6]   = '{2, 2, 2, 2, 2, 1};
        int ws [6]    = '{60, 60, 500, 500, 500, 500};
        int pots [6]  = '{60, 20, 20, 20, 420, 400};
        bit spks [6]  = '{0, 1, 0, 0, 1, 1};
        do_reset(16'sd100, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3 || i == 4) pulse_sweep();
            drive_event(ids[i], ws[i]);
            n_checks++;
            if ({upd_valid, spike, upd_potential} !== {1'b1, spks[i], 16'(pots[i])}) begin
                n_fail++;
                $display("FAIL refrac_step%0d: got v%b s%b p%0d want v1 s%b p%0d", i, upd_valid, spike, upd_potential, spks[i], pots[i]);
            end
        end
    endtask

    task automatic test_leak();
        int busy_n, done_n, done_at, rdy_bad;
        int exp0 [2] = '{48, 36};
        do_reset(16'sd1000, 1'b0, 4'd2);
        drive_event(0, 64);
        drive_event(1, -64);
        for (int rep = 0; rep < 2; rep++) begin
            ts_step = 1'b1;
            @(posedge clk);
            #1 ts_step = 1'b0;
            busy_n = 0; done_n = 0; done_at = -1; rdy_bad = 0;
            for (int c = 0; c < 8; c++) begin
                if (busy === 1'b1) busy_n++;
                if (done === 1'b1) begin
                    done_n++;
                    done_at = c;
                end
                if (in_ready !== (!busy && !ts_step)) rdy_bad++;
                // second sweep: a ts_step mid-sweep must be ignored
                ts_step = (rep == 1 && c == 1);
                @(posedge clk);
                #1;
            end
            ts_step = 1'b0;
            n_checks++;
            if (busy_n !== 4) begin
                n_fail++;
                $display("FAIL leak_busy_cycles rep%0d: got %0d want 4", rep, busy_n);
            end
            n_checks++;
            if (done_n !== 1 || done_at !== 4) begin
                n_fail++;
                $display("FAIL leak_done rep%0d: got count %0d at %0d want count 1 at 4", rep, done_n, done_at);
            end
            n_checks++;
            if (rdy_bad !== 0) begin
                n_fail++;
                $display("FAIL leak_in_ready rep%0d: %0d bad samples want 0", rep, rdy_bad);
            end
            drive_event(0, 0);
            n_checks++;
            if (upd_potential !== 16'(exp0[rep])) begin
                n_fail++;
                $display("FAIL leak_v0 rep%0d: got %0d want %0d", rep, upd_potential, exp0[rep]);
            end
            drive_event(1, 0);
            n_checks++;
            if (upd_potential !== 16'(-exp0[rep])) begin
                n_fail++;
                $display("FAIL leak_v1 rep%0d: got %0d want %0d", rep, upd_potential, -exp0[rep]);
            end
        end
    endtask

    task automatic test_saturation();
        int ids [6]  = '{0, 0, 1, 1, 3, 2};
        int ws [6]   = '{20000, 20000, -20000, -20000, 32767, -32768};
        int pots [6] = '{20000, 0, -20000, -32768, 32767, -32768};
        bit spks [6] = '{0, 1, 0, 0, 1, 0};
        do_reset(16'sd32767, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) do_reset(-16'sd100, 1'b0, 4'd0);
            drive_event(ids[i], ws[i]);
            n_checks++;
            if ({upd_valid, spike, upd_potential} !== {1'b1, spks[i], 16'(pots[i])}) begin
                n_fail++;
                $display("FAIL sat_step%0d: got v%b s%b p%0d want v1 s%b p%0d", i, upd_valid, spike, upd_potential, spks[i], pots[i]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_n, busy_n;
        do_reset(16'sd100, 1'b0, 4'd1);
        drive_event(0, 90);
        drive_event(1, 150);
        drive_event(3, -40);
        ts_step = 1'b1;
        @(posedge clk);
        #1 ts_step = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({busy, done, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL midrst_state: got b%b d%b r%b want b0 d0 r1", busy, done, in_ready);
        end
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1) done_n++;
            if (busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (done_n !== 0 || busy_n !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got done %0d busy %0d want 0 0", done_n, busy_n);
        end
        drive_event(0, 0);
        n_checks++;
        if (upd_potential !== 16'sd0) begin
            n_fail++;
            $display("FAIL midrst_v0: got %0d want 0", upd_potential);
        end
        drive_event(1, 5);
        n_checks++;
        if ({spike, upd_potential} !== {1'b0, 16'sd5}) begin
            n_fail++;
            $display("FAIL midrst_v1: got s%b p%0d want s0 p5", spike, upd_potential);
        end
        drive_event(3, 0);
        n_checks++;
        if (upd_potential !== 16'sd0) begin
            n_fail++;
            $display("FAIL midrst_v3: got %0d want 0", upd_potential);
        end
    endtask

    task automatic test_stall();
        int waited, early;
        bit got;
        do_reset(16'sd1000, 1'b0, 4'd1);
        drive_event(0, 200);
        in_valid     = 1'b1;
        in_neuron_id = 2'd0;
        in_weight    = 16'sd10;
        ts_step      = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready_on_ts: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1 ts_step = 1'b0;
        waited = 0; early = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (in_ready === 1'b1) begin
                got = 1'b1;
            end else begin
                if (upd_valid === 1'b1) early++;
                @(posedge clk);
                #1;
                waited++;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++;
        if (!got || waited !== N || early !== 0) begin
            n_fail++;
            $display("FAIL stall_wait: got ready %b after %0d cycles (early upd %0d) want ready after %0d", got, waited, early, N);
        end
        n_checks++;
        if ({upd_valid, upd_potential} !== {1'b1, 16'sd110}) begin
            n_fail++;
            $display("FAIL stall_result: got v%b p%0d want v1 p110", upd_valid, upd_potential);
        end
    endtask

    task automatic test_random();
        int id, w, r, pot;
        bit sp;
        for (int round = 0; round < 3; round++) begin
            do_reset(16'($urandom_range(50, 3000)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 5)));
            for (int op = 0; op < 150; op++) begin
                r = int'($urandom_range(0, 99));
                if (r < 12) begin
                    pulse_sweep();
                    model_sweep();
                end else begin
                    id = int'($urandom_range(0, N - 1));
                    if (r < 25) w = int'($urandom_range(0, 65535)) - 32768;
                    else w = int'($urandom_range(0, 1200)) - 600;
                    model_event(id, w, pot, sp);
                    drive_event(id, w);
                    n_checks++;
                    if ({upd_valid, upd_id, spike, upd_potential} !== {1'b1, 2'(id), sp, 16'(pot)}) begin
                        n_fail++;
                        $display("FAIL rand r%0d op%0d: got v%b id%0d s%b p%0d want v1 id%0d s%b p%0d", round, op, upd_valid, upd_id, spike, upd_potential, id, sp, pot);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_refractory();
        test_leak();
        test_saturation();
        test_reset_mid_sweep();
        test_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
